// File: rtl/led_bar_counter_pkg.sv
// Shared constants for the push-button bar-graph level meter.
// Key indices into the raw key bus and the level-width helper.
package led_bar_pkg;

  localparam int KEY_CLR  = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;
  localparam int KEY_MODE = 3;

  function automatic int lw_of(input int n_leds);
    return $clog2(n_leds + 1);
  endfunction

endpackage

// File: rtl/led_bar_counter_if.sv
// Board-side bundle of the level meter: raw buttons in, LED bank and status out.
interface led_bar_counter_if
  import led_bar_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int LW     = lw_of(N_LEDS)
) ();

  logic [3:0]        key;
  logic [N_LEDS-1:0] led;
  logic [LW-1:0]     level;
  logic              blink_en;

  modport master (output key, input led, level, blink_en);
  modport slave  (input key, output led, level, blink_en);

endinterface

// File: rtl/led_bar_counter_key_debounce.sv
// One push-button front end: 2-FF synchroniser, stability debounce, press pulse
// and an optional hold-to-repeat timer that adds pulses while the key stays down.
module key_debounce #(
  parameter int DB_CYCLES  = 250000,
  parameter int REPEAT_EN  = 0,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

  logic           sync1_q, sync2_q;
  logic           db_q, db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           rise;
  logic           press_q;
  logic           rpt_act_q;
  logic [RW-1:0]  rpt_cnt_q;
  logic           rpt_fire;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    rise     = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
        db_d = sync2_q;
        rise = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Gated on db_d so a release landing this cycle suppresses the pulse.
  assign rpt_fire = (REPEAT_EN != 0) && rpt_act_q && db_d && (rpt_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      rpt_act_q <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      sync1_q  <= ~key_n_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= rise | rpt_fire;
      if (rise) begin
        rpt_act_q <= (REPEAT_EN != 0);
        rpt_cnt_q <= RW'(REPEAT_DLY - 1);
      end else if (!db_d) begin
        rpt_act_q <= 1'b0;
        rpt_cnt_q <= '0;
      end else if (rpt_act_q) begin
        if (rpt_cnt_q == '0) begin
          rpt_cnt_q <= RW'(REPEAT_PER - 1);
        end else begin
          rpt_cnt_q <= rpt_cnt_q - 1'b1;
        end
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_bar_counter.sv
// Button-driven saturating level meter shown as a thermometer code on N_LEDS LEDs,
// either blinking at BLINK_HZ or steady; key[3] toggles the display mode.
module led_bar_counter
  import led_bar_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int BLINK_HZ   = 1,
  parameter int DB_CYCLES  = 250000,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int REPEAT_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  led_bar_counter_if.slave   bus
);

  localparam int LW = lw_of(N_LEDS);
  localparam int P  = CLK_HZ / BLINK_HZ;
  localparam int BW = (P > 2) ? $clog2(P) : 1;

  logic              press_clr, press_inc, press_dec, press_mode;
  logic [LW-1:0]     level_q, level_d;
  logic              blink_q, blink_d;
  logic [BW-1:0]     bcnt_q;
  logic              phase_on;
  logic [N_LEDS-1:0] led_q, led_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES), .REPEAT_EN(0),
                 .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_db_clr  (.clk(clk), .rst_n(rst_n), .key_n_i(bus.key[KEY_CLR]),  .press_o(press_clr));

  key_debounce #(.DB_CYCLES(DB_CYCLES), .REPEAT_EN(REPEAT_EN),
                 .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_db_inc  (.clk(clk), .rst_n(rst_n), .key_n_i(bus.key[KEY_INC]),  .press_o(press_inc));

  key_debounce #(.DB_CYCLES(DB_CYCLES), .REPEAT_EN(REPEAT_EN),
                 .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_db_dec  (.clk(clk), .rst_n(rst_n), .key_n_i(bus.key[KEY_DEC]),  .press_o(press_dec));

  key_debounce #(.DB_CYCLES(DB_CYCLES), .REPEAT_EN(0),
                 .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_db_mode (.clk(clk), .rst_n(rst_n), .key_n_i(bus.key[KEY_MODE]), .press_o(press_mode));

  assign phase_on = (bcnt_q < BW'(P / 2));

  always_comb begin
    level_d = level_q;
    if (press_clr) begin
      level_d = '0;
    end else if (press_inc) begin
      if (level_q != LW'(N_LEDS)) level_d = level_q + 1'b1;
    end else if (press_dec) begin
      if (level_q != '0) level_d = level_q - 1'b1;
    end
    blink_d = blink_q ^ press_mode;
    led_d   = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      led_d[i] = (LW'(i) < level_q) && (phase_on || !blink_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      blink_q <= 1'b1;
      bcnt_q  <= '0;
      led_q   <= '0;
    end else begin
      level_q <= level_d;
      blink_q <= blink_d;
      bcnt_q  <= (bcnt_q == BW'(P - 1)) ? '0 : bcnt_q + 1'b1;
      led_q   <= led_d;
    end
  end

  assign bus.level    = level_q;
  assign bus.blink_en = blink_q;
  assign bus.led      = led_q;

endmodule

// File: tb/tb_led_bar_counter.sv
// Directed bench for led_bar_counter: expected levels queued as keys are driven,
// popped at sample points; LED pattern predicted from a blink-phase model.
module tb_led_bar_counter
  import led_bar_pkg::*;
;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int P  = 16;

  logic clk;
  logic rst_n;
  logic [3:0] key_r;

  int checks;
  int errors;
  int lvl_m;
  bit blink_m;
  int bcnt;

  string tag_q[$];
  int    exp_q[$];

  led_bar_counter_if #(.N_LEDS(N)) bus ();
  assign bus.key = key_r;

  led_bar_counter #(
    .N_LEDS(N), .CLK_HZ(16), .BLINK_HZ(1), .DB_CYCLES(DB),
    .REPEAT_DLY(20), .REPEAT_PER(8), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else        bcnt <= (bcnt == P - 1) ? 0 : bcnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop_level();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: observed=empty expected=entry");
    end else begin
      string t;
      int    e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, 32'(bus.level), e);
    end
  endtask

  function automatic logic [N-1:0] exp_led(input int lvl, input bit blink);
    logic [N-1:0] t;
    int prev;
    prev = (bcnt + P - 1) % P;
    for (int i = 0; i < N; i++) t[i] = (i < lvl);
    return ((prev < P / 2) || !blink) ? t : '0;
  endfunction

  task automatic press(input int k);
    key_r[k] = 1'b0;
    tick(DB + 6);
    key_r[k] = 1'b1;
    tick(DB + 6);
  endtask

  task automatic inc_press();
    lvl_m = (lvl_m < N) ? lvl_m + 1 : N;
    sb_push("inc_press", lvl_m);
    press(KEY_INC);
    sb_pop_level();
  endtask

  task automatic dec_press();
    lvl_m = (lvl_m > 0) ? lvl_m - 1 : 0;
    sb_push("dec_press", lvl_m);
    press(KEY_DEC);
    sb_pop_level();
  endtask

  task automatic clr_press();
    lvl_m = 0;
    sb_push("clr_press", lvl_m);
    press(KEY_CLR);
    sb_pop_level();
  endtask

  int hold_exp[8] = '{0, 1, 1, 2, 2, 3, 4, 4};
  int hold_gap[8] = '{6, 1, 19, 1, 7, 1, 8, 23};

  initial begin
    checks  = 0;
    errors  = 0;
    lvl_m   = 0;
    blink_m = 1'b1;
    key_r   = 4'hF;
    rst_n   = 1'b0;
    tick(3);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_blink", 32'(bus.blink_en), 1);
    chk("rst_led", 32'(bus.led), 0);
    rst_n = 1'b1;

    // three presses, then one full blink period of LED pattern
    repeat (3) inc_press();
    for (int i = 0; i < P; i++) begin
      tick(1);
      chk("blink_l3", 32'(bus.led), 32'(exp_led(lvl_m, blink_m)));
    end

    clr_press();
    repeat (6) inc_press();
    repeat (5) dec_press();

    // bounce shorter than the window produces nothing
    sb_push("bounce_none", lvl_m);
    repeat (3) begin
      key_r[KEY_INC] = 1'b0; tick(3);
      key_r[KEY_INC] = 1'b1; tick(2);
    end
    tick(DB + 6);
    sb_pop_level();
    lvl_m = lvl_m + 1;
    sb_push("bounce_one", lvl_m);
    key_r[KEY_INC] = 1'b0; tick(10);
    key_r[KEY_INC] = 1'b1; tick(DB + 6);
    sb_pop_level();

    // auto-repeat: pulses at offsets 0,20,28,36,... after the press pulse
    clr_press();
    for (int i = 0; i < 8; i++) sb_push($sformatf("hold_inc_%0d", i), hold_exp[i]);
    key_r[KEY_INC] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(hold_gap[i]);
      sb_pop_level();
    end
    key_r[KEY_INC] = 1'b1;
    tick(DB + 6);
    lvl_m = N;

    // held clear fires once; an inc during the hold must survive
    key_r[KEY_CLR] = 1'b0;
    lvl_m = 0;
    sb_push("hold_clr", lvl_m);
    tick(10);
    sb_pop_level();
    inc_press();
    tick(30);
    sb_push("clr_no_repeat", lvl_m);
    sb_pop_level();
    key_r[KEY_CLR] = 1'b1;
    tick(DB + 6);

    // steady mode
    inc_press();
    press(KEY_MODE);
    blink_m = 1'b0;
    chk("mode_steady", 32'(bus.blink_en), 32'(blink_m));
    for (int i = 0; i < 2 * P; i++) begin
      tick(1);
      chk("steady_led", 32'(bus.led), 32'(exp_led(lvl_m, blink_m)));
    end
    press(KEY_MODE);
    blink_m = 1'b1;
    chk("mode_blink", 32'(bus.blink_en), 32'(blink_m));
    for (int i = 0; i < P; i++) begin
      tick(1);
      chk("reblink_led", 32'(bus.led), 32'(exp_led(lvl_m, blink_m)));
    end

    // simultaneous inc and dec: inc wins
    lvl_m = lvl_m + 1;
    sb_push("inc_dec_same", lvl_m);
    key_r[KEY_INC] = 1'b0;
    key_r[KEY_DEC] = 1'b0;
    tick(DB + 6);
    key_r[KEY_INC] = 1'b1;
    key_r[KEY_DEC] = 1'b1;
    tick(DB + 6);
    sb_pop_level();

    // reset in the middle of a repeat hold
    dec_press();
    lvl_m = lvl_m + 1;
    sb_push("hold_before_rst", lvl_m);
    key_r[KEY_INC] = 1'b0;
    tick(7);
    sb_pop_level();
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(bus.level), 0);
    chk("midrst_led", 32'(bus.led), 0);
    chk("midrst_blink", 32'(bus.blink_en), 1);
    lvl_m   = 0;
    blink_m = 1'b1;
    tick(1);
    rst_n = 1'b1;
    sb_push("post_rst_quiet", 0);
    sb_push("post_rst_event", 1);
    tick(DB + 2);
    sb_pop_level();
    tick(1);
    sb_pop_level();
    lvl_m = 1;
    key_r[KEY_INC] = 1'b1;
    tick(DB + 6);
    for (int i = 0; i < P; i++) begin
      tick(1);
      chk("post_rst_led", 32'(bus.led), 32'(exp_led(lvl_m, blink_m)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_bar_counter.md
# led_bar_counter

Parametrised button-driven bar-graph level meter. Four raw push-buttons clear, increment, decrement and toggle blink mode on a saturating level counter. The level is displayed as a thermometer code on `N_LEDS` LEDs, which either blink at `BLINK_HZ` or stay lit. The block sits at board top level between the push-button pins and the green LED bank, and supersedes the fixed 3-bit, 7-LED, edge-only version.

## Interface
- `N_LEDS`, 8: number of LEDs and maximum level; ≥ 2.
- `CLK_HZ`, 50000000: `clk` frequency in Hz.
- `BLINK_HZ`, 1: blink rate. `P = CLK_HZ / BLINK_HZ` cycles; P must be even and ≥ 2.
- `DB_CYCLES`, 250000: debounce stability window in cycles (5 ms at 50 MHz); ≥ 1.
- `REPEAT_DLY`, 25000000: hold time before auto-repeat starts, in cycles.
- `REPEAT_PER`, 5000000: auto-repeat period, in cycles.
- `REPEAT_EN`, 1: 1 enables auto-repeat on increment/decrement.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key`, in, 4: raw, asynchronous, active-low buttons. `key[0]` = clear, `[1]` = inc, `[2]` = dec, `[3]` = mode.
- `led`, out, `N_LEDS`: registered LED drive, active-high.
- `level`, out, `LW = $clog2(N_LEDS+1)`: current level, 0..`N_LEDS`.
- `blink_en`, out, 1: 1 = blink mode, 0 = steady mode.

## Operation
- **Reset** (`rst_n` = 0), asynchronous, may occur at any time, including mid-debounce or mid-repeat:
  - `level` = 0, `blink_en` = 1, `led` = 0.
  - Blink counter = 0; all debounce and repeat counters = 0.
  - Debounced key state = released.
- **Per-key front end:**
  - 2-FF synchroniser.
  - Debounced state changes only after the synchronised value has differed from it for `DB_CYCLES` consecutive cycles. Any shorter glitch restarts the count and produces no event.
  - Press pulse: a one-cycle `press` when the debounced state goes released → pressed. Release produces no event.
- **Auto-repeat** (`key[1]`, `key[2]` only, when `REPEAT_EN` = 1):
  - While the debounced key stays pressed, an extra pulse fires `REPEAT_DLY` cycles after the press pulse.
  - Further pulses follow every `REPEAT_PER` cycles.
  - Release stops repeats immediately.
- **Level update**, priority clear > inc > dec within one cycle:
  - clear: `level` ← 0.
  - inc: `level` ← min(`level`+1, `N_LEDS`). Saturates; no wrap.
  - dec: `level` ← max(`level`−1, 0). Saturates; no wrap.
  - Simultaneous inc and dec pulses: inc wins, dec is dropped.
- **Mode:** a `key[3]` press pulse toggles `blink_en`, independent of the level-update priority.
- **Blink counter:**
  - Counts 0..P−1 and wraps to 0. Free-running; not reset by a mode change.
  - `phase_on` = (count < P/2).
- **LED output:** `led[i]` ← (i < `level`) & (`phase_on` | ~`blink_en`), registered.
- `level` = 0 gives all LEDs off in both modes. `level` = `N_LEDS` gives all LEDs on in the on-phase.

## Timing
- Raw key edge (clean) to press pulse: 2 sync cycles + `DB_CYCLES` cycles.
- Press pulse to `level`/`blink_en` update: 1 cycle (registered on the edge ending the pulse cycle).
- `level`/`blink_en` change to `led`: 1 further cycle.
- Blink: `led` on for P/2 cycles, then off for P/2 cycles, lagging the counter by 1 cycle.
- Auto-repeat pulses land exactly at cycle offsets `REPEAT_DLY`, `REPEAT_DLY`+`REPEAT_PER`, … after the press pulse.
- After `rst_n` deasserts, no event can occur for at least `DB_CYCLES`+2 cycles.

## Structure
- Package `led_bar_pkg`:
  - key index constants `KEY_CLR`=0, `KEY_INC`=1, `KEY_DEC`=2, `KEY_MODE`=3.
  - the `LW` width computation.
- Sub-module `key_debounce`, instantiated 4×:
  - contains the synchroniser, stability counter, press detector and optional repeat timer.
  - parameters `DB_CYCLES`, `REPEAT_EN`, `REPEAT_DLY`, `REPEAT_PER`; `REPEAT_EN` is tied to 0 for clear and mode.
- Top level contains the level register, mode register, blink counter and LED register.

## Test plan
Bench parameters: `N_LEDS`=4, `CLK_HZ`=16, `BLINK_HZ`=1 (P=16), `DB_CYCLES`=4, `REPEAT_DLY`=20, `REPEAT_PER`=8.
- Reset, then three clean inc presses → `level`=3. In the on-phase `led`=4'b0111, off-phase `led`=0, 8 cycles each.
- Six inc presses from 0 → `level` saturates at 4. Then five dec presses → `level`=0, no wrap to 4.
- Bounce on `key[1]`: low pulses of 3 cycles separated by 2-cycle highs, then a 10-cycle stable low → exactly one increment.
- Hold inc for 60 cycles after the press pulse → pulses at offsets 0, 20, 28, 36, 44, 52 → `level` 0→4, saturated. Hold clear → exactly one clear, no repeat.
- Mode press with `level`=2 → `blink_en`=0, `led`=4'b0011 steady for 32 cycles. A second press restores blinking. A same-cycle inc+dec pulse (forced via debouncer release timing) → `level`+1.
- Assert `rst_n`=0 mid-repeat with `level`=3 → `level`=0, `led`=0, `blink_en`=1 immediately. Key still held after reset → no event until `DB_CYCLES`+2 cycles have elapsed.
